axi_lite_cmd_master: RTL

AXI_LITE_CMD_MASTER -- requirements
Module: axi_lite_cmd_master

---
 rtl/axi_bridge_pkg.sv | 25 ++
 rtl/axi4_lite_if.sv | 34 +++
 rtl/axi_timeout_counter.sv | 28 ++
 rtl/axi_lite_cmd_master.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/axi_bridge_pkg.sv
// axi_bridge_pkg: shared types and constants for the AXI4-Lite command bridge.
//   state_t      - command master FSM states
//   ST_*         - rsp_status codes returned to the command side
//   RESP_*       - AXI4-Lite BRESP/RRESP encodings
//   map_resp()   - folds an AXI response into a rsp_status code
package axi_bridge_pkg;

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;

    localparam logic [1:0] ST_OKAY    = 2'd0;
    localparam logic [1:0] ST_SLVERR  = 2'd1;
    localparam logic [1:0] ST_DECERR  = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // EXOKAY has no meaning for a lite master, so it folds into OKAY.
    function automatic logic [1:0] map_resp(input logic [1:0] r);
        return r == RESP_SLVERR ? ST_SLVERR : r == RESP_DECERR ? ST_DECERR : ST_OKAY;
    endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// axi4_lite_if: AXI4-Lite bus bundle.
//   AW/W/B/AR/R channels with valid/ready handshakes; master drives the
//   request side of each channel, slave drives the ready/response side.
interface axi4_lite_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    awvalid, awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    wvalid, wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    bvalid, bready;
    logic [1:0]              bresp;
    logic                    arvalid, arready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    rvalid, rready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_timeout_counter.sv
// axi_timeout_counter: per-transaction cycle counter with limit compare.
//   clk, rst - clock, synchronous active-high reset
//   clr      - restart the count at zero
//   en       - count this cycle
//   limit    - cycle budget; 0 disables expiry
//   expired  - the count reaches limit on this clock edge
module axi_timeout_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] limit,
    output logic        expired
);
    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en && cnt != '1)
            cnt <= cnt + 16'd1;
    end

    // Looks one increment ahead so the owner leaves on the very edge the count
    // hits limit; >= keeps it asserted if a handshake postponed the reaction.
    assign expired = en && limit != '0 && ({1'b0, cnt} + 17'd1 >= {1'b0, limit});

endmodule

// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master: single-outstanding command to AXI4-Lite master bridge.
//   clk, rst             - clock, synchronous active-high reset
//   cmd_valid/cmd_ready  - command handshake (write flag, addr, wdata, wstrb)
//   timeout_cfg          - timeout in TIMEOUT_SCALE units, 0 disables; sampled at accept
//   rsp_valid/rsp_ready  - response handshake (rsp_rdata, rsp_status)
//   busy                 - a command is in flight
//   axi                  - AXI4-Lite master port
module axi_lite_cmd_master
    import axi_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int TIMEOUT_SCALE = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    input  logic [7:0]              timeout_cfg,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_status,
    output logic                    busy,
    axi4_lite_if.master             axi
);
    state_t      state;
    logic [7:0]  tcfg;
    logic [15:0] limit;
    logic        expired;
    logic        hs;

    assign busy       = state != IDLE;
    assign axi.awprot = 3'b000;
    assign axi.arprot = 3'b000;
    assign limit      = 16'(tcfg) * 16'(TIMEOUT_SCALE);

    axi_timeout_counter u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (cmd_valid && cmd_ready),
        .en      (state != IDLE && state != DONE),
        .limit   (limit),
        .expired (expired)
    );

    // Completion of the current wait state; a handshake beats a simultaneous timeout.
    always_comb
        hs = state == WR_REQ  ? (!axi.awvalid || axi.awready) && (!axi.wvalid || axi.wready) :
             state == WR_RESP ? axi.bvalid :
             state == RD_REQ  ? axi.arready :
             state == RD_RESP ? axi.rvalid : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tcfg        <= '0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_status  <= ST_OKAY;
            axi.awvalid <= 1'b0;
            axi.wvalid  <= 1'b0;
            axi.bready  <= 1'b0;
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b0;
        end else if (expired && !hs) begin
            axi.awvalid <= 1'b0;
            axi.wvalid  <= 1'b0;
            axi.bready  <= 1'b0;
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b0;
            rsp_status  <= ST_TIMEOUT;
            rsp_rdata   <= '0;
            rsp_valid   <= 1'b1;
            state       <= DONE;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready   <= 1'b0;
                        tcfg        <= timeout_cfg;
                        axi.awaddr  <= cmd_addr;
                        axi.araddr  <= cmd_addr;
                        axi.wdata   <= cmd_wdata;
                        axi.wstrb   <= cmd_wstrb;
                        axi.awvalid <= cmd_write;
                        axi.wvalid  <= cmd_write;
                        axi.arvalid <= !cmd_write;
                        state       <= cmd_write ? WR_REQ : RD_REQ;
                    end
                end
                WR_REQ: begin
                    if (axi.awready) axi.awvalid <= 1'b0;
                    if (axi.wready)  axi.wvalid  <= 1'b0;
                    if (hs) begin
                        axi.bready <= 1'b1;
                        state      <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (axi.bvalid) begin
                        axi.bready <= 1'b0;
                        rsp_status <= map_resp(axi.bresp);
                        rsp_rdata  <= '0;
                        rsp_valid  <= 1'b1;
                        state      <= DONE;
                    end
                end
                RD_REQ: begin
                    if (axi.arready) begin
                        axi.arvalid <= 1'b0;
                        axi.rready  <= 1'b1;
                        state       <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (axi.rvalid) begin
                        axi.rready <= 1'b0;
                        rsp_status <= map_resp(axi.rresp);
                        rsp_rdata  <= axi.rdata;
                        rsp_valid  <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
